alu_exec: RTL and testbench

//  Integer execute stage directly downstream of ALURS. Takes one ready ALU op per cycle
//  (operands already resolved), computes the RV32I integer result, and broadcasts it on
//  the ALU CDB (valid/tag/data). The CDB feeds ALURS, LSB, ROB and the branch RS.

---
 rtl/alu_exec.sv | 117 +++++++++++
 tb/tb_alu_exec.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// RV32I integer execute stage: one ALU op per cycle from ALURS, result broadcast on the ALU CDB.
// The datapath is combinational on the issue inputs; only the CDB valid/tag/data triple is registered.
module alu_exec #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              ALU_valid,
    input  logic [OP_W-1:0]   ALU_op,
    input  logic [DATA_W-1:0] ALU_reg1,
    input  logic [DATA_W-1:0] ALU_reg2,
    input  logic [DATA_W-1:0] ALU_imm,
    input  logic [DATA_W-1:0] ALU_pc,
    input  logic [TAG_W-1:0]  ALU_reg_des_rob,
    output logic              ALU_cdb_valid,
    output logic [TAG_W-1:0]  ALU_cdb_tag,
    output logic [DATA_W-1:0] ALU_cdb_data
);

    // Opcode encodings shared with the decoder; branch/jump/memory codes never reach this unit.
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [TAG_W-1:0]  ZERO_TAG  = {TAG_W{1'b0}};

    logic [4:0]        shamt_reg_s;
    logic [4:0]        shamt_imm_s;
    logic              lt_s;
    logic              ltu_s;
    logic              lti_s;
    logic              ltiu_s;
    logic [DATA_W-1:0] result_s;

    assign shamt_reg_s = ALU_reg2[4:0];
    assign shamt_imm_s = ALU_imm[4:0];
    assign lt_s        = $signed(ALU_reg1) < $signed(ALU_reg2);
    assign ltu_s       = ALU_reg1 < ALU_reg2;
    assign lti_s       = $signed(ALU_reg1) < $signed(ALU_imm);
    assign ltiu_s      = ALU_reg1 < ALU_imm;

    // Result mux; unknown opcodes yield zero so the ROB entry still completes.
    always_comb begin
        result_s = ZERO_DATA;
        case (ALU_op)
            OP_LUI:   result_s = ALU_imm;
            OP_AUIPC: result_s = ALU_pc + ALU_imm;
            OP_ADD:   result_s = ALU_reg1 + ALU_reg2;
            OP_SUB:   result_s = ALU_reg1 - ALU_reg2;
            OP_XOR:   result_s = ALU_reg1 ^ ALU_reg2;
            OP_OR:    result_s = ALU_reg1 | ALU_reg2;
            OP_AND:   result_s = ALU_reg1 & ALU_reg2;
            OP_ADDI:  result_s = ALU_reg1 + ALU_imm;
            OP_XORI:  result_s = ALU_reg1 ^ ALU_imm;
            OP_ORI:   result_s = ALU_reg1 | ALU_imm;
            OP_ANDI:  result_s = ALU_reg1 & ALU_imm;
            OP_SLT:   result_s = {{(DATA_W-1){1'b0}}, lt_s};
            OP_SLTU:  result_s = {{(DATA_W-1){1'b0}}, ltu_s};
            OP_SLTI:  result_s = {{(DATA_W-1){1'b0}}, lti_s};
            OP_SLTIU: result_s = {{(DATA_W-1){1'b0}}, ltiu_s};
            OP_SLL:   result_s = ALU_reg1 << shamt_reg_s;
            OP_SRL:   result_s = ALU_reg1 >> shamt_reg_s;
            OP_SRA:   result_s = DATA_W'($signed(ALU_reg1) >>> shamt_reg_s);
            OP_SLLI:  result_s = ALU_reg1 << shamt_imm_s;
            OP_SRLI:  result_s = ALU_reg1 >> shamt_imm_s;
            OP_SRAI:  result_s = DATA_W'($signed(ALU_reg1) >>> shamt_imm_s);
            default:  result_s = ZERO_DATA;
        endcase
    end

    // CDB register: reset wins, rdy low freezes everything, clear drops any concurrent issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_cdb_valid <= 1'b0;
            ALU_cdb_tag   <= ZERO_TAG;
            ALU_cdb_data  <= ZERO_DATA;
        end else if (rdy) begin
            if (clear || !ALU_valid) begin
                ALU_cdb_valid <= 1'b0;
                ALU_cdb_tag   <= ZERO_TAG;
                ALU_cdb_data  <= ZERO_DATA;
            end else begin
                ALU_cdb_valid <= 1'b1;
                ALU_cdb_tag   <= ALU_reg_des_rob;
                ALU_cdb_data  <= result_s;
            end
        end else begin
            ALU_cdb_valid <= ALU_cdb_valid;
            ALU_cdb_tag   <= ALU_cdb_tag;
            ALU_cdb_data  <= ALU_cdb_data;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: a table of hand-computed op vectors issued back-to-back,
// plus short sequences for reset, clear, and rdy stall behaviour.
module tb_alu_exec;

    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;
    localparam logic [5:0] OP_BAD   = 6'd63;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_reg1;
    logic [31:0] alu_reg2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    alu_exec #(.DATA_W(32), .TAG_W(4), .OP_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clear           (clear),
        .ALU_valid       (alu_valid),
        .ALU_op          (alu_op),
        .ALU_reg1        (alu_reg1),
        .ALU_reg2        (alu_reg2),
        .ALU_imm         (alu_imm),
        .ALU_pc          (alu_pc),
        .ALU_reg_des_rob (alu_tag),
        .ALU_cdb_valid   (cdb_valid),
        .ALU_cdb_tag     (cdb_tag),
        .ALU_cdb_data    (cdb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_cdb(input string name, input logic v, input logic [3:0] t, input logic [31:0] d);
        chk({name, ".valid"}, {31'd0, cdb_valid}, {31'd0, v});
        chk({name, ".tag"}, {28'd0, cdb_tag}, {28'd0, t});
        chk({name, ".data"}, cdb_data, d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        alu_valid = 1'b1;
        alu_op    = op;
        alu_reg1  = r1;
        alu_reg2  = r2;
        alu_imm   = imm;
        alu_pc    = pc;
        alu_tag   = tag;
    endtask

    task automatic add_vec(input string name, input logic [5:0] op, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] pc,
                           input logic [3:0] tag, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.reg1 = r1; v.reg2 = r2;
        v.imm = imm; v.pc = pc; v.tag = tag; v.exp_data = exp;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        add_vec("add",   OP_ADD,   32'd7,          32'hFFFFFFFF, 32'd0,        32'd0,      4'd3,  32'd6);
        add_vec("sub",   OP_SUB,   32'd5,          32'd7,        32'd0,        32'd0,      4'd4,  32'hFFFFFFFE);
        add_vec("xor",   OP_XOR,   32'hF0F0F0F0,   32'hFF00FF00, 32'd0,        32'd0,      4'd5,  32'h0FF00FF0);
        add_vec("or",    OP_OR,    32'hF0F0F0F0,   32'hFF00FF00, 32'd0,        32'd0,      4'd6,  32'hFFF0FFF0);
        add_vec("and",   OP_AND,   32'hF0F0F0F0,   32'hFF00FF00, 32'd0,        32'd0,      4'd7,  32'hF000F000);
        add_vec("addi",  OP_ADDI,  32'd10,         32'd99,       32'hFFFFFFFF, 32'd0,      4'd8,  32'd9);
        add_vec("xori",  OP_XORI,  32'h0000FFFF,   32'd0,        32'hFFFFF800, 32'd0,      4'd9,  32'hFFFF07FF);
        add_vec("ori",   OP_ORI,   32'h12340000,   32'd0,        32'h00000056, 32'd0,      4'd10, 32'h12340056);
        add_vec("andi",  OP_ANDI,  32'h12345678,   32'd0,        32'hFFFFFFF0, 32'd0,      4'd11, 32'h12345670);
        add_vec("sra",   OP_SRA,   32'h80000000,   32'h00000024, 32'd0,        32'd0,      4'd12, 32'hF8000000);
        add_vec("srli",  OP_SRLI,  32'h80000000,   32'd0,        32'd4,        32'd0,      4'd13, 32'h08000000);
        add_vec("srai",  OP_SRAI,  32'h80000000,   32'd0,        32'h0000003F, 32'd0,      4'd14, 32'hFFFFFFFF);
        add_vec("sll",   OP_SLL,   32'd1,          32'h00000021, 32'd0,        32'd0,      4'd15, 32'd2);
        add_vec("srl",   OP_SRL,   32'h80000000,   32'd31,       32'd0,        32'd0,      4'd0,  32'd1);
        add_vec("slli",  OP_SLLI,  32'd3,          32'd0,        32'd4,        32'd0,      4'd1,  32'h30);
        add_vec("slt",   OP_SLT,   32'hFFFFFFFF,   32'd1,        32'd0,        32'd0,      4'd2,  32'd1);
        add_vec("sltu",  OP_SLTU,  32'hFFFFFFFF,   32'd1,        32'd0,        32'd0,      4'd3,  32'd0);
        add_vec("slti",  OP_SLTI,  32'd5,          32'd0,        32'hFFFFFFFF, 32'd0,      4'd4,  32'd0);
        add_vec("sltiu", OP_SLTIU, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd0,      4'd5,  32'd1);
        add_vec("auipc", OP_AUIPC, 32'd0,          32'd0,        32'h00002000, 32'h1000,   4'd6,  32'h3000);
        add_vec("lui",   OP_LUI,   32'hDEADBEEF,   32'd0,        32'h12345000, 32'h4,      4'd7,  32'h12345000);
        add_vec("bad",   OP_BAD,   32'h11111111,   32'h22222222, 32'h33333333, 32'h44,     4'd9,  32'd0);

        // Reset with an issue presented: outputs stay cleared.
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd5);
        step();
        chk_cdb("reset_c1", 1'b0, 4'd0, 32'd0);
        step();
        chk_cdb("reset_c2", 1'b0, 4'd0, 32'd0);
        rst = 1'b0;

        // Table vectors issued back-to-back, one result per cycle.
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].reg1, vecs[i].reg2, vecs[i].imm, vecs[i].pc, vecs[i].tag);
            step();
            chk_cdb(vecs[i].name, 1'b1, vecs[i].tag, vecs[i].exp_data);
        end
        alu_valid = 1'b0;
        step();
        chk_cdb("idle_after_table", 1'b0, 4'd0, 32'd0);

        // Tags 1,2,3 back-to-back, with clear landing on the tag 2 issue.
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
        step();
        chk_cdb("b2b_t1", 1'b1, 4'd1, 32'd2);
        issue(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 4'd2);
        clear = 1'b1;
        step();
        chk_cdb("b2b_t2_cleared", 1'b0, 4'd0, 32'd0);
        clear = 1'b0;
        issue(OP_ADD, 32'd3, 32'd3, 32'd0, 32'd0, 4'd3);
        step();
        chk_cdb("b2b_t3", 1'b1, 4'd3, 32'd6);

        // Stall: result held while rdy is low, even with a new issue presented.
        issue(OP_ADDI, 32'd1, 32'd0, 32'd1, 32'd0, 4'd5);
        step();
        chk_cdb("stall_load", 1'b1, 4'd5, 32'd2);
        rdy = 1'b0;
        issue(OP_SUB, 32'd100, 32'd1, 32'd0, 32'd0, 4'd12);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_cdb($sformatf("stall_hold%0d", k), 1'b1, 4'd5, 32'd2);
        end
        clear = 1'b1;
        step();
        chk_cdb("stall_clear_ignored", 1'b1, 4'd5, 32'd2);
        clear = 1'b0;
        rdy = 1'b1;
        alu_valid = 1'b0;
        step();
        chk_cdb("stall_release_idle", 1'b0, 4'd0, 32'd0);

        // Reset overrides rdy low.
        issue(OP_LUI, 32'd0, 32'd0, 32'hABCDE000, 32'd0, 4'd8);
        step();
        chk_cdb("pre_reset_load", 1'b1, 4'd8, 32'hABCDE000);
        rdy = 1'b0;
        rst = 1'b1;
        step();
        chk_cdb("reset_over_rdy", 1'b0, 4'd0, 32'd0);
        rst = 1'b0;
        rdy = 1'b1;
        alu_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
